// File: rtl/bcd_to_bin_seq_if.sv
// Handshake/data bundle for the sequential BCD-to-binary converter.
// master drives a request, slave returns status and result.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 2,
  parameter int BW     = 7
);
  logic                  Start;
  logic [4*DIGITS-1:0]   BCD;
  logic                  Busy;
  logic                  Done;
  logic [BW-1:0]         Bin;
  logic                  Err;

  modport master (output Start, BCD, input Busy, Done, Bin, Err);
  modport slave  (input Start, BCD, output Busy, Done, Bin, Err);
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble: shift right, subtract 3).
// One bit per cycle; invalid digits are rejected on the first shift cycle.
module bcd_to_bin_seq #(
  parameter int DIGITS = 2,
  parameter int BW     = 7
) (
  input  logic           Clock,
  input  logic           Resetn,
  bcd_to_bin_seq_if.slave io
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    d_q, b_q;
  logic [W-1:0]    d_nx, b_nx;
  logic [2*W-1:0]  sh;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bin_q;
  logic            err_q;
  logic [DIGITS-1:0] bad;
  logic            reject, last;

  // Datapath: R = {D, B} shifted right one bit, then BCD nibble correction.
  assign sh   = {d_q, b_q} >> 1;
  assign b_nx = sh[W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [3:0] nib;
    assign nib              = sh[W + 4*g +: 4];
    assign d_nx[4*g +: 4]   = (nib >= 4'd8) ? nib - 4'd3 : nib;
    assign bad[g]           = d_q[4*g +: 4] > 4'd9;
  end

  // Captured digits are still untouched on the first SHIFT cycle, so check them there.
  assign reject = (cnt == '0) && (|bad);
  assign last   = (cnt == CW'(W - 1));

  // State register
  always_ff @(posedge Clock) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (io.Start) state_nx = SHIFT;
      SHIFT:   if (reject || last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    io.Busy = 1'b0;
    io.Done = 1'b0;
    case (state)
      SHIFT:   io.Busy = 1'b1;
      DONE:    begin io.Busy = 1'b1; io.Done = 1'b1; end
      default: ;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      d_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      bin_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.Start) begin
          d_q   <= io.BCD;
          b_q   <= '0;
          cnt   <= '0;
          err_q <= 1'b0;
        end
        SHIFT: begin
          if (reject) begin
            err_q <= 1'b1;
            bin_q <= '0;
          end else begin
            d_q <= d_nx;
            b_q <= b_nx;
            cnt <= cnt + 1'b1;
            if (last) bin_q <= b_nx[BW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign io.Bin = bin_q;
  assign io.Err = err_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed + randomized bench for bcd_to_bin_seq (DIGITS=2, BW=7).
// Reference model is plain decimal arithmetic on the digit values.
module tb_bcd_to_bin_seq;
  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bcd_to_bin_seq_if #(.DIGITS(2), .BW(7)) io ();

  bcd_to_bin_seq #(.DIGITS(2), .BW(7)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .io     (io)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal value of the digits, or error if any nibble is not a digit.
  function automatic logic [7:0] ref_conv(input logic [7:0] v);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9 || lo > 9) return 8'h80;
    return 8'(hi * 10 + lo);
  endfunction

  // Issue one request, wait (bounded) for Done, return result and edges from accept to Done.
  task automatic run(input logic [7:0] v, output logic [6:0] b, output logic e, output int lat);
    io.Start = 1'b1;
    io.BCD   = v;
    tick();
    io.Start = 1'b0;
    io.BCD   = 8'($urandom);
    lat = 0;
    while (!io.Done && lat < 30) begin
      tick();
      lat++;
    end
    if (lat >= 30) chk("done_timeout", 32'(lat), 32'd8);
    b = io.Bin;
    e = io.Err;
    tick();
    chk("done_one_cycle", 32'(io.Done), 32'd0);
  endtask

  initial begin
    logic [6:0] b;
    logic       e;
    int         lat, n, prev, k;
    logic [7:0] v, m;

    // Reset with Start asserted
    io.Start = 1'b1;
    io.BCD   = 8'h45;
    tick();
    tick();
    chk("rst_busy", 32'(io.Busy), 0);
    chk("rst_done", 32'(io.Done), 0);
    chk("rst_bin",  32'(io.Bin),  0);
    chk("rst_err",  32'(io.Err),  0);
    io.Start = 1'b0;
    Resetn   = 1'b1;
    tick();
    chk("idle_busy", 32'(io.Busy), 0);

    // Basic conversions
    run(8'h45, b, e, lat);
    chk("h45_bin", 32'(b), 32'h2D); chk("h45_err", 32'(e), 0); chk("h45_lat", 32'(lat), 8);
    run(8'h99, b, e, lat);
    chk("h99_bin", 32'(b), 32'h63); chk("h99_lat", 32'(lat), 8);
    run(8'h00, b, e, lat);
    chk("h00_bin", 32'(b), 32'h00); chk("h00_err", 32'(e), 0);
    run(8'h10, b, e, lat);
    chk("h10_bin", 32'(b), 32'h0A);

    // Invalid digit, then recovery
    run(8'h3A, b, e, lat);
    chk("h3A_err", 32'(e), 1); chk("h3A_bin", 32'(b), 0); chk("h3A_lat", 32'(lat), 1);
    tick();
    chk("err_held", 32'(io.Err), 1);
    io.Start = 1'b1; io.BCD = 8'h12;
    tick();
    io.Start = 1'b0;
    chk("err_clr_at_accept", 32'(io.Err), 0);
    n = 0;
    while (!io.Done && n < 30) begin tick(); n++; end
    chk("h12_bin", 32'(io.Bin), 32'h0C);
    tick();

    // Start while busy is ignored
    io.Start = 1'b1; io.BCD = 8'h27;
    tick();
    io.Start = 1'b0;
    tick(); tick();
    io.Start = 1'b1; io.BCD = 8'h81;
    tick();
    io.Start = 1'b0;
    n = 0;
    for (int i = 0; i < 25; i++) begin
      if (io.Done) begin
        n++;
        chk("busy_bin", 32'(io.Bin), 32'h1B);
      end
      tick();
    end
    chk("busy_single_done", 32'(n), 1);

    // Reset mid-conversion
    io.Start = 1'b1; io.BCD = 8'h64;
    tick();
    io.Start = 1'b0;
    tick(); tick(); tick();
    Resetn = 1'b0;
    tick();
    chk("midrst_busy", 32'(io.Busy), 0);
    chk("midrst_done", 32'(io.Done), 0);
    chk("midrst_bin",  32'(io.Bin),  0);
    chk("midrst_err",  32'(io.Err),  0);
    Resetn = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (io.Done) n++;
      tick();
    end
    chk("midrst_no_done", 32'(n), 0);
    run(8'h64, b, e, lat);
    chk("h64_bin", 32'(b), 32'h40);

    // Back-to-back with Start held high
    io.Start = 1'b1; io.BCD = 8'h50;
    n = 0; prev = -1;
    for (k = 0; k < 40; k++) begin
      tick();
      if (io.Done) begin
        n++;
        chk("b2b_bin", 32'(io.Bin), 32'h32);
        if (prev >= 0) chk("b2b_period", 32'(k - prev), 10);
        prev = k;
      end
    end
    chk("b2b_count_ge3", 32'(n >= 3), 1);
    io.Start = 1'b0;
    n = 0;
    while (io.Busy && n < 30) begin tick(); n++; end
    chk("b2b_drain", 32'(io.Busy), 0);

    // Exhaustive valid inputs
    for (int i = 0; i < 100; i++) begin
      v = {4'(i / 10), 4'(i % 10)};
      run(v, b, e, lat);
      chk("exh_bin", 32'(b), 32'(i));
      chk("exh_err", 32'(e), 0);
    end

    // Random inputs (valid and invalid) against the model
    for (int i = 0; i < 150; i++) begin
      v = 8'($urandom);
      m = ref_conv(v);
      run(v, b, e, lat);
      chk("rnd_err", 32'(e), 32'(m[7]));
      chk("rnd_bin", 32'(b), m[7] ? 32'd0 : 32'(m[6:0]));
      chk("rnd_lat", 32'(lat), m[7] ? 32'd1 : 32'd8);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
